// File: rtl/seq_mux.sv
// Sequential channel multiplexer: selects one of N_CH input channels either by
// an explicit index load (manual mode) or by stepping through the channels at a
// fixed cycle rate (scan mode). All outputs are registered.
module seq_mux #(
  parameter  int N_CH     = 4,
  parameter  int WIDTH    = 1,
  parameter  int SCAN_DIV = 12_000_000,
  localparam int SELW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_CH*WIDTH-1:0]   i_data,
  input  logic [SELW-1:0]         i_sel,
  input  logic                    i_sel_load,
  input  logic                    i_mode,
  output logic [WIDTH-1:0]        o_data,
  output logic [SELW-1:0]         o_ch,
  output logic                    o_tick,
  output logic                    o_err
);

  localparam int CNTW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // Channel count widened by one bit so every i_sel value can be compared
  // against it, including the all-ones pattern for non-power-of-two N_CH.
  localparam logic [SELW:0]   N_CH_EXT = (SELW+1)'(N_CH);
  localparam logic [SELW-1:0] LAST_CH  = SELW'(N_CH - 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(SCAN_DIV - 1);

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_t;

  state_t          state;
  logic [SELW-1:0] ch;
  logic [SELW-1:0] ch_next;
  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] cnt_next;
  logic [WIDTH-1:0] ch_data;
  logic [WIDTH-1:0] data_q;
  logic            tick_q;
  logic            err_q;

  logic sel_valid;
  logic load_ok;
  logic load_bad;

  assign sel_valid = ({1'b0, i_sel} < N_CH_EXT);
  assign load_ok   = i_sel_load &  sel_valid;
  assign load_bad  = i_sel_load & ~sel_valid;

  // Next channel and divider count: a valid load wins over a divider advance,
  // a rejected load freezes both, manual mode pins the divider at zero.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the branches leaves it unassigned and infers a latch.
    ch_next  = ch;
    cnt_next = cnt;
    if (load_ok) begin
      ch_next  = i_sel;
      cnt_next = '0;
    end else if (!load_bad) begin
      if (state == MANUAL) begin
        cnt_next = '0;
      end else if (cnt == CNT_LAST) begin
        cnt_next = '0;
        ch_next  = (ch == LAST_CH) ? '0 : ch + 1'b1;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  // Slice of the currently selected channel out of the packed input bus.
  always_comb begin
    ch_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (ch == SELW'(k)) begin
        ch_data = i_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Mode follower, channel/divider state and registered outputs.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_rst) begin
      state  <= MANUAL;
      ch     <= '0;
      cnt    <= '0;
      data_q <= '0;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= i_mode ? SCAN : MANUAL;
      ch     <= ch_next;
      cnt    <= cnt_next;
      data_q <= ch_data;
      tick_q <= (ch_next != ch);
      err_q  <= load_bad;
    end
  end

  assign o_data = data_q;
  assign o_ch   = ch;
  assign o_tick = tick_q;
  assign o_err  = err_q;

endmodule

// File: tb/tb_seq_mux.sv
// Self-checking bench for seq_mux. Two instances share the control inputs:
// dut_a (4 channels x 8 bits, divider 3) and dut_b (3 channels x 8 bits,
// divider 3) for the non-power-of-two out-of-range cases. Each scenario stages
// stimulus rows with hand-derived expected outputs; the expectation is pushed
// to the scoreboard when its row is driven and popped when the DUT responds.
module tb_seq_mux;

  localparam logic [31:0] D  = 32'h4433_2211;
  localparam logic [31:0] D2 = 32'h4455_2211;
  localparam logic [31:0] DB = 32'h00CC_BBAA;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic        load;
  logic [1:0]  sel;
  logic [31:0] data;

  logic [1:0]  a_ch;
  logic [7:0]  a_data;
  logic        a_tick;
  logic        a_err;
  logic [1:0]  b_ch;
  logic [7:0]  b_data;
  logic        b_tick;
  logic        b_err;

  typedef struct packed {
    logic        rst;
    logic        mode;
    logic        load;
    logic [1:0]  sel;
    logic [31:0] data;
  } stim_t;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
    logic       tick;
    logic       err;
  } obs_t;

  stim_t stage_s[$];
  obs_t  stage_e[$];
  obs_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  seq_mux #(.N_CH(4), .WIDTH(8), .SCAN_DIV(3)) dut_a (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_data     (data),
    .i_sel      (sel),
    .i_sel_load (load),
    .i_mode     (mode),
    .o_data     (a_data),
    .o_ch       (a_ch),
    .o_tick     (a_tick),
    .o_err      (a_err)
  );

  seq_mux #(.N_CH(3), .WIDTH(8), .SCAN_DIV(3)) dut_b (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_data     (data[23:0]),
    .i_sel      (sel),
    .i_sel_load (load),
    .i_mode     (mode),
    .o_data     (b_data),
    .o_ch       (b_ch),
    .o_tick     (b_tick),
    .o_err      (b_err)
  );

  // Stage one cycle: inputs for the next edge and the outputs expected after it.
  task automatic row(input logic r, input logic m, input logic l,
                     input logic [1:0] s, input logic [31:0] d,
                     input logic [1:0] ec, input logic [7:0] ed,
                     input logic et, input logic ee);
    stim_t st;
    obs_t  ex;
    st = {r, m, l, s, d};
    ex = {ec, ed, et, ee};
    stage_s.push_back(st);
    stage_e.push_back(ex);
  endtask

  task automatic drive(input stim_t st);
    rst  = st.rst;
    mode = st.mode;
    load = st.load;
    sel  = st.sel;
    data = st.data;
  endtask

  // Advance one clock and settle just past the edge before sampling.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, want;
    int   step = 0;
    row(1, 1, 1, 2'd3, D, 2'd0, 8'h00, 1'b0, 1'b0);
    row(1, 1, 1, 2'd3, D, 2'd0, 8'h00, 1'b0, 1'b0);
    row(0, 0, 0, 2'd0, D, 2'd0, 8'h11, 1'b0, 1'b0);
    while (stage_s.size() > 0) begin
      drive(stage_s.pop_front());
      exp_q.push_back(stage_e.pop_front());
      cyc();
      want = exp_q.pop_front();
      got  = {a_ch, a_data, a_tick, a_err};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset step %0d: got ch=%0d data=%h tick=%b err=%b, want ch=%0d data=%h tick=%b err=%b",
                 step, got.ch, got.data, got.tick, got.err, want.ch, want.data, want.tick, want.err);
      end
      step++;
    end
  endtask

  task automatic test_manual_load();
    obs_t got, want;
    int   step = 0;
    row(1, 0, 0, 2'd0, D,  2'd0, 8'h00, 1'b0, 1'b0);
    row(0, 0, 0, 2'd0, D,  2'd0, 8'h11, 1'b0, 1'b0);
    row(0, 0, 1, 2'd2, D,  2'd2, 8'h11, 1'b1, 1'b0);
    row(0, 0, 0, 2'd0, D,  2'd2, 8'h33, 1'b0, 1'b0);
    row(0, 0, 0, 2'd0, D2, 2'd2, 8'h55, 1'b0, 1'b0);
    row(0, 0, 1, 2'd2, D2, 2'd2, 8'h55, 1'b0, 1'b0);
    row(0, 0, 0, 2'd0, D,  2'd2, 8'h33, 1'b0, 1'b0);
    while (stage_s.size() > 0) begin
      drive(stage_s.pop_front());
      exp_q.push_back(stage_e.pop_front());
      cyc();
      want = exp_q.pop_front();
      got  = {a_ch, a_data, a_tick, a_err};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL manual_load step %0d: got ch=%0d data=%h tick=%b err=%b, want ch=%0d data=%h tick=%b err=%b",
                 step, got.ch, got.data, got.tick, got.err, want.ch, want.data, want.tick, want.err);
      end
      step++;
    end
  endtask

  task automatic test_out_of_range();
    obs_t got, want;
    int   step = 0;
    row(1, 0, 0, 2'd0, DB, 2'd0, 8'h00, 1'b0, 1'b0);
    row(0, 0, 1, 2'd1, DB, 2'd1, 8'hAA, 1'b1, 1'b0);
    row(0, 0, 1, 2'd3, DB, 2'd1, 8'hBB, 1'b0, 1'b1);
    row(0, 0, 0, 2'd0, DB, 2'd1, 8'hBB, 1'b0, 1'b0);
    row(0, 0, 1, 2'd2, DB, 2'd2, 8'hBB, 1'b1, 1'b0);
    row(0, 0, 0, 2'd0, DB, 2'd2, 8'hCC, 1'b0, 1'b0);
    row(0, 1, 0, 2'd0, DB, 2'd2, 8'hCC, 1'b0, 1'b0);
    row(0, 1, 1, 2'd3, DB, 2'd2, 8'hCC, 1'b0, 1'b1);
    row(0, 1, 0, 2'd0, DB, 2'd2, 8'hCC, 1'b0, 1'b0);
    row(0, 1, 0, 2'd0, DB, 2'd2, 8'hCC, 1'b0, 1'b0);
    row(0, 1, 0, 2'd0, DB, 2'd0, 8'hCC, 1'b1, 1'b0);
    while (stage_s.size() > 0) begin
      drive(stage_s.pop_front());
      exp_q.push_back(stage_e.pop_front());
      cyc();
      want = exp_q.pop_front();
      got  = {b_ch, b_data, b_tick, b_err};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL out_of_range step %0d: got ch=%0d data=%h tick=%b err=%b, want ch=%0d data=%h tick=%b err=%b",
                 step, got.ch, got.data, got.tick, got.err, want.ch, want.data, want.tick, want.err);
      end
      step++;
    end
  endtask

  task automatic test_scan_wrap();
    obs_t got, want;
    int   step = 0;
    row(1, 0, 0, 2'd0, D, 2'd0, 8'h00, 1'b0, 1'b0);
    row(0, 0, 1, 2'd3, D, 2'd3, 8'h11, 1'b1, 1'b0);
    row(0, 1, 0, 2'd0, D, 2'd3, 8'h44, 1'b0, 1'b0);
    row(0, 1, 0, 2'd0, D, 2'd3, 8'h44, 1'b0, 1'b0);
    row(0, 1, 0, 2'd0, D, 2'd3, 8'h44, 1'b0, 1'b0);
    row(0, 1, 0, 2'd0, D, 2'd0, 8'h44, 1'b1, 1'b0);
    row(0, 1, 0, 2'd0, D, 2'd0, 8'h11, 1'b0, 1'b0);
    row(0, 1, 0, 2'd0, D, 2'd0, 8'h11, 1'b0, 1'b0);
    row(0, 1, 0, 2'd0, D, 2'd1, 8'h11, 1'b1, 1'b0);
    row(0, 1, 0, 2'd0, D, 2'd1, 8'h22, 1'b0, 1'b0);
    while (stage_s.size() > 0) begin
      drive(stage_s.pop_front());
      exp_q.push_back(stage_e.pop_front());
      cyc();
      want = exp_q.pop_front();
      got  = {a_ch, a_data, a_tick, a_err};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL scan_wrap step %0d: got ch=%0d data=%h tick=%b err=%b, want ch=%0d data=%h tick=%b err=%b",
                 step, got.ch, got.data, got.tick, got.err, want.ch, want.data, want.tick, want.err);
      end
      step++;
    end
  endtask

  task automatic test_collision();
    obs_t got, want;
    int   step = 0;
    row(1, 0, 0, 2'd0, D, 2'd0, 8'h00, 1'b0, 1'b0);
    row(0, 0, 1, 2'd2, D, 2'd2, 8'h11, 1'b1, 1'b0);
    row(0, 1, 0, 2'd0, D, 2'd2, 8'h33, 1'b0, 1'b0);
    row(0, 1, 0, 2'd0, D, 2'd2, 8'h33, 1'b0, 1'b0);
    row(0, 1, 0, 2'd0, D, 2'd2, 8'h33, 1'b0, 1'b0);
    row(0, 1, 1, 2'd1, D, 2'd1, 8'h33, 1'b1, 1'b0);
    row(0, 1, 0, 2'd0, D, 2'd1, 8'h22, 1'b0, 1'b0);
    row(0, 1, 0, 2'd0, D, 2'd1, 8'h22, 1'b0, 1'b0);
    row(0, 1, 0, 2'd0, D, 2'd2, 8'h22, 1'b1, 1'b0);
    row(0, 1, 0, 2'd0, D, 2'd2, 8'h33, 1'b0, 1'b0);
    while (stage_s.size() > 0) begin
      drive(stage_s.pop_front());
      exp_q.push_back(stage_e.pop_front());
      cyc();
      want = exp_q.pop_front();
      got  = {a_ch, a_data, a_tick, a_err};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL collision step %0d: got ch=%0d data=%h tick=%b err=%b, want ch=%0d data=%h tick=%b err=%b",
                 step, got.ch, got.data, got.tick, got.err, want.ch, want.data, want.tick, want.err);
      end
      step++;
    end
  endtask

  task automatic test_mode_toggle();
    obs_t got, want;
    int   step = 0;
    row(1, 1, 0, 2'd0, D, 2'd0, 8'h00, 1'b0, 1'b0);
    row(0, 1, 0, 2'd0, D, 2'd0, 8'h11, 1'b0, 1'b0);
    row(0, 1, 0, 2'd0, D, 2'd0, 8'h11, 1'b0, 1'b0);
    row(0, 1, 0, 2'd0, D, 2'd0, 8'h11, 1'b0, 1'b0);
    row(0, 1, 0, 2'd0, D, 2'd1, 8'h11, 1'b1, 1'b0);
    row(0, 1, 0, 2'd0, D, 2'd1, 8'h22, 1'b0, 1'b0);
    row(0, 1, 0, 2'd0, D, 2'd1, 8'h22, 1'b0, 1'b0);
    row(0, 1, 0, 2'd0, D, 2'd2, 8'h22, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) begin
      row(0, 0, 0, 2'd0, D, 2'd2, 8'h33, 1'b0, 1'b0);
    end
    row(0, 1, 0, 2'd0, D, 2'd2, 8'h33, 1'b0, 1'b0);
    row(0, 1, 0, 2'd0, D, 2'd2, 8'h33, 1'b0, 1'b0);
    row(0, 1, 0, 2'd0, D, 2'd2, 8'h33, 1'b0, 1'b0);
    row(0, 1, 0, 2'd0, D, 2'd3, 8'h33, 1'b1, 1'b0);
    while (stage_s.size() > 0) begin
      drive(stage_s.pop_front());
      exp_q.push_back(stage_e.pop_front());
      cyc();
      want = exp_q.pop_front();
      got  = {a_ch, a_data, a_tick, a_err};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL mode_toggle step %0d: got ch=%0d data=%h tick=%b err=%b, want ch=%0d data=%h tick=%b err=%b",
                 step, got.ch, got.data, got.tick, got.err, want.ch, want.data, want.tick, want.err);
      end
      step++;
    end
  endtask

  task automatic test_reset_mid_scan();
    obs_t got, want;
    int   step = 0;
    row(1, 0, 0, 2'd0, D, 2'd0, 8'h00, 1'b0, 1'b0);
    row(0, 0, 1, 2'd3, D, 2'd3, 8'h11, 1'b1, 1'b0);
    row(0, 1, 0, 2'd0, D, 2'd3, 8'h44, 1'b0, 1'b0);
    row(0, 1, 0, 2'd0, D, 2'd3, 8'h44, 1'b0, 1'b0);
    row(1, 1, 0, 2'd0, D, 2'd0, 8'h00, 1'b0, 1'b0);
    row(0, 1, 0, 2'd0, D, 2'd0, 8'h11, 1'b0, 1'b0);
    row(0, 1, 0, 2'd0, D, 2'd0, 8'h11, 1'b0, 1'b0);
    row(0, 1, 0, 2'd0, D, 2'd0, 8'h11, 1'b0, 1'b0);
    row(0, 1, 0, 2'd0, D, 2'd1, 8'h11, 1'b1, 1'b0);
    while (stage_s.size() > 0) begin
      drive(stage_s.pop_front());
      exp_q.push_back(stage_e.pop_front());
      cyc();
      want = exp_q.pop_front();
      got  = {a_ch, a_data, a_tick, a_err};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid_scan step %0d: got ch=%0d data=%h tick=%b err=%b, want ch=%0d data=%h tick=%b err=%b",
                 step, got.ch, got.data, got.tick, got.err, want.ch, want.data, want.tick, want.err);
      end
      step++;
    end
  endtask

  task automatic test_back_to_back();
    obs_t got, want;
    int   step = 0;
    row(1, 0, 0, 2'd0, D, 2'd0, 8'h00, 1'b0, 1'b0);
    row(0, 0, 1, 2'd1, D, 2'd1, 8'h11, 1'b1, 1'b0);
    row(0, 0, 1, 2'd2, D, 2'd2, 8'h22, 1'b1, 1'b0);
    row(0, 0, 1, 2'd2, D, 2'd2, 8'h33, 1'b0, 1'b0);
    row(0, 0, 1, 2'd3, D, 2'd3, 8'h33, 1'b1, 1'b0);
    row(0, 0, 1, 2'd0, D, 2'd0, 8'h44, 1'b1, 1'b0);
    row(0, 0, 0, 2'd0, D, 2'd0, 8'h11, 1'b0, 1'b0);
    while (stage_s.size() > 0) begin
      drive(stage_s.pop_front());
      exp_q.push_back(stage_e.pop_front());
      cyc();
      want = exp_q.pop_front();
      got  = {a_ch, a_data, a_tick, a_err};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL back_to_back step %0d: got ch=%0d data=%h tick=%b err=%b, want ch=%0d data=%h tick=%b err=%b",
                 step, got.ch, got.data, got.tick, got.err, want.ch, want.data, want.tick, want.err);
      end
      step++;
    end
  endtask

  initial begin
    rst  = 1'b1;
    mode = 1'b0;
    load = 1'b0;
    sel  = 2'd0;
    data = '0;
    test_reset();
    test_manual_load();
    test_out_of_range();
    test_scan_wrap();
    test_collision();
    test_mode_toggle();
    test_reset_mid_scan();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so a stalled run still terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/seq_mux.md
SEQ_MUX -- requirements
Module: seq_mux

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of input channels (legal 2..16).
REQ-002 SHALL have parameter WIDTH, default 1, bits per channel.
REQ-003 SHALL have parameter SCAN_DIV, default 12_000_000, cycles per channel in scan mode (legal >= 2).
REQ-004 SHALL have derived localparam SELW = clog2(N_CH), minimum 1.
REQ-005 SHALL have i_clk, input, 1, the single clock.
REQ-006 SHALL have i_rst, input, 1, synchronous, active-high reset.
REQ-007 SHALL have i_data, input, N_CH*WIDTH, channel k in bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have i_sel, input, SELW, requested channel index.
REQ-009 SHALL have i_sel_load, input, 1, single-cycle strobe that captures i_sel.
REQ-010 SHALL have i_mode, input, 1, 0 = manual, 1 = auto-scan.
REQ-011 SHALL have o_data, output, WIDTH, registered selected-channel data.
REQ-012 SHALL have o_ch, output, SELW, currently selected channel index.
REQ-013 SHALL have o_tick, output, 1, one-cycle pulse when o_ch changes.
REQ-014 SHALL have o_err, output, 1, one-cycle pulse on an out-of-range load.

Function
REQ-015 SHALL implement FSM states MANUAL and SCAN; state is i_mode registered, one-cycle follow latency.
REQ-016 SHALL hold ch (drives o_ch) and divider counter cnt (0..SCAN_DIV-1).
REQ-017 SHALL, in MANUAL, change ch only on i_sel_load with i_sel < N_CH; cnt held at 0.
REQ-018 SHALL, in SCAN, increment cnt each cycle; at cnt == SCAN_DIV-1, set cnt to 0 and ch to ch+1, wrapping N_CH-1 -> 0.
REQ-019 SHALL, in SCAN, on a valid i_sel_load, set ch = i_sel and cnt = 0; the load overrides a same-cycle divider advance.
REQ-020 SHALL, on i_sel_load with i_sel >= N_CH (either state), leave ch and cnt unchanged and pulse o_err next cycle.
REQ-021 SHALL, on MANUAL -> SCAN transition, clear cnt and keep ch (scan resumes from current channel).
REQ-022 SHALL, on SCAN -> MANUAL transition, freeze ch at its current value.
REQ-023 SHALL register o_data from i_data slice of ch every cycle: o_data at cycle t+1 = slice(ch at t) of i_data at t (1-cycle latency, data changes propagate without a load).
REQ-024 SHALL assert o_tick for exactly one cycle, aligned with the first cycle o_ch shows a new value; loading the same index as ch gives no o_tick.
REQ-025 SHALL produce no combinational path from any input to any output.

Reset
REQ-026 SHALL, while i_rst is high at a clock edge, set state MANUAL, ch 0, cnt 0, o_data 0, o_tick 0, o_err 0.
REQ-027 SHALL give i_rst priority over i_sel_load and divider advance; reset mid-scan aborts the count.
REQ-028 SHALL resume operation on the first edge after i_rst falls, state per registered i_mode.

Verification
REQ-029 SHALL cover manual load: N_CH=4, WIDTH=8, i_data=0x44_33_22_11, load i_sel=2 -> o_ch=2, o_tick pulse, o_data=0x33 one cycle later.
REQ-030 SHALL cover out-of-range: N_CH=3, load i_sel=3 -> o_err one cycle, o_ch unchanged, no o_tick.
REQ-031 SHALL cover scan wrap: N_CH=4, SCAN_DIV=3, i_mode=1 from ch=3 -> o_ch 3,0,1 changing every 3 cycles, o_tick per change.
REQ-032 SHALL cover load/advance collision: SCAN, cnt=SCAN_DIV-1, load i_sel=1 with ch=2 -> ch=1, cnt=0, not 3.
REQ-033 SHALL cover mode toggle: scan to ch=2, set i_mode=0 -> ch stays 2 for 100 cycles; set i_mode=1 -> next advance after SCAN_DIV cycles.
REQ-034 SHALL cover reset mid-scan: assert i_rst at ch=3 -> next cycle o_ch=0, o_data=0, o_tick=0.
